// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame controller:
// parser state encoding, default frame header, command opcodes,
// error codes and the frame checksum helper.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } frame_state_e;

    localparam logic [7:0] FRAME_HDR_DEF = 8'hA5;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_CMD     = 2'd3;

    // Frame checksum: 8-bit wrapping sum of cmd, addr and data.
    function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                              input logic [7:0] addr,
                                              input logic [7:0] data);
        return cmd + addr + data;
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Bus bundle between the UART receiver / register file and the frame
// controller. The controller uses the slave view; whoever feeds bytes and
// watches the register strobes uses the master view.
interface uart_frame_ctrl_if;
    logic        uart_done;
    logic [7:0]  uart_data;
    logic        reg_wr;
    logic        rd_req;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    modport master (
        output uart_done, uart_data,
        input  reg_wr, rd_req, reg_addr, reg_wdata,
        input  frame_err, err_code, busy, good_cnt, err_cnt
    );

    modport slave (
        input  uart_done, uart_data,
        output reg_wr, rd_req, reg_addr, reg_wdata,
        output frame_err, err_code, busy, good_cnt, err_cnt
    );
endinterface

// File: rtl/uart_byte_stb.sv
// Turns the receiver's level-style done flag into exactly one strobe per
// byte (rising edge of done) and presents the byte valid in that cycle.
module uart_byte_stb (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       done_i,
    input  logic [7:0] data_i,
    output logic       stb_o,
    output logic [7:0] byte_o
);
    logic done_q;

    // Delayed copy of done for rising-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_i;
        end
    end

    assign stb_o  = done_i & ~done_q;
    assign byte_o = data_i;
endmodule

// File: rtl/uart_frame_ctrl.sv
// UART command-frame controller: assembles header/cmd/addr/data/checksum
// frames from the receiver byte stream, issues one-cycle register write or
// read-request strobes, reports framing errors and drops a frame whose
// bytes stop arriving for TIMEOUT_BYTES character times.
// Optional build macro UART_FRAME_STAT_EN adds saturating good/error frame
// counters; without it good_cnt and err_cnt read as zero.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         UART_BPS      = 9600,
    parameter int         TIMEOUT_BYTES = 4,
    parameter logic [7:0] FRAME_HDR     = FRAME_HDR_DEF
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    uart_frame_ctrl_if.slave bus
);
    // Silence limit in clock cycles: TIMEOUT_BYTES characters of 10 bits.
    localparam int              TO_MAX   = (CLK_FREQ / UART_BPS) * 10 * TIMEOUT_BYTES;
    localparam int              TO_W     = $clog2(TO_MAX + 1);
    localparam logic [TO_W-1:0] TO_MAX_V = TO_W'(TO_MAX);
    localparam logic [TO_W-1:0] TO_ZERO  = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    logic       stb_s;
    logic [7:0] byte_s;

    frame_state_e    state_q, state_d;
    logic [7:0]      cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            reg_wr_q, reg_wr_d, rd_req_q, rd_req_d;
    logic [7:0]      reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;

    uart_byte_stb u_byte_stb (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .done_i (bus.uart_done),
        .data_i (bus.uart_data),
        .stb_o  (stb_s),
        .byte_o (byte_s)
    );

    // Parser state, latched frame fields, silence counter and output strobes.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            to_cnt_q    <= TO_ZERO;
            reg_wr_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            to_cnt_q    <= to_cnt_d;
            reg_wr_q    <= reg_wr_d;
            rd_req_q    <= rd_req_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Next-state, field capture, frame decode and timeout; a byte strobe
    // always takes priority over an expiring silence counter.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        to_cnt_d    = to_cnt_q;
        reg_wr_d    = 1'b0;
        rd_req_d    = 1'b0;
        frame_err_d = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        err_code_d  = err_code_q;

        if (stb_s) begin
            to_cnt_d = TO_ZERO;
            case (state_q)
                ST_IDLE: begin
                    if (byte_s == FRAME_HDR) begin
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    cmd_d   = byte_s;
                    state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_d  = byte_s;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    data_d  = byte_s;
                    state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (byte_s != frame_csum(cmd_q, addr_q, data_q)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end else if (cmd_q == CMD_WR) begin
                        reg_wr_d    = 1'b1;
                        reg_addr_d  = addr_q;
                        reg_wdata_d = data_q;
                    end else if (cmd_q == CMD_RD) begin
                        rd_req_d    = 1'b1;
                        reg_addr_d  = addr_q;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CMD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TO_MAX_V) begin
                state_d     = ST_IDLE;
                to_cnt_d    = TO_ZERO;
                frame_err_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
            end else begin
                to_cnt_d = to_cnt_q + TO_ONE;
            end
        end else begin
            to_cnt_d = TO_ZERO;
        end
    end

    assign bus.reg_wr    = reg_wr_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = (state_q != ST_IDLE);

`ifdef UART_FRAME_STAT_EN
    logic [15:0] good_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating counters of accepted frames and error strobes, updated on
    // the same edge that raises the corresponding strobe.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            good_cnt_q <= 16'h0000;
            err_cnt_q  <= 16'h0000;
        end else begin
            if ((reg_wr_d || rd_req_d) && (good_cnt_q != 16'hFFFF)) begin
                good_cnt_q <= good_cnt_q + 16'h0001;
            end
            if (frame_err_d && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'h0001;
            end
        end
    end

    assign bus.good_cnt = good_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
`else
    assign bus.good_cnt = 16'h0000;
    assign bus.err_cnt  = 16'h0000;
`endif
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl. A frame-level reference model
// (byte queue plus "cycles since last byte") predicts every output on every
// clock; directed scenarios add literal expectations, then random traffic.
module tb_uart_frame_ctrl;
    localparam int CLK_FREQ = 192_000;
    localparam int BPS      = 9600;
    localparam int TOB      = 4;
    localparam int TO_MAX   = (CLK_FREQ / BPS) * 10 * TOB;   // 800 cycles

    logic clk;
    logic rst;
    uart_frame_ctrl_if bif ();

    uart_frame_ctrl #(
        .CLK_FREQ      (CLK_FREQ),
        .UART_BPS      (BPS),
        .TIMEOUT_BYTES (TOB),
        .FRAME_HDR     (8'hA5)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_wr = 0, n_rd = 0, n_ferr = 0;

    // ---------------- reference model ----------------
    bit       m_prev_done;
    bit       m_in_frame;
    int       m_body[$];
    int       m_since;
    bit       exp_wr, exp_rd, exp_ferr;
    int       exp_addr, exp_wdata, exp_code, exp_good, exp_errc;

    task automatic model_err(input int code);
        exp_ferr = 1'b1;
        exp_code = code;
        if (exp_errc < 65535) exp_errc++;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_prev_done = 1'b0; m_in_frame = 1'b0; m_body.delete(); m_since = 0;
            exp_wr = 1'b0; exp_rd = 1'b0; exp_ferr = 1'b0;
            exp_addr = 0; exp_wdata = 0; exp_code = 0; exp_good = 0; exp_errc = 0;
        end else begin
            exp_wr = 1'b0; exp_rd = 1'b0; exp_ferr = 1'b0;
            if (bif.uart_done && !m_prev_done) begin
                m_since = 0;
                if (!m_in_frame) begin
                    m_in_frame = (bif.uart_data == 8'hA5);
                end else begin
                    m_body.push_back(int'(bif.uart_data));
                    if (m_body.size() == 4) begin
                        if (((m_body[0] + m_body[1] + m_body[2]) % 256) != m_body[3]) model_err(2);
                        else if (m_body[0] == 1) begin
                            exp_wr = 1'b1; exp_addr = m_body[1]; exp_wdata = m_body[2];
                            if (exp_good < 65535) exp_good++;
                        end else if (m_body[0] == 2) begin
                            exp_rd = 1'b1; exp_addr = m_body[1];
                            if (exp_good < 65535) exp_good++;
                        end else model_err(3);
                        m_body.delete();
                        m_in_frame = 1'b0;
                    end
                end
            end else begin
                m_since++;
                if (m_in_frame && m_since == TO_MAX + 1) begin
                    model_err(1);
                    m_in_frame = 1'b0;
                    m_body.delete();
                end
            end
            m_prev_done = bif.uart_done;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        begin
            int eg, ee;
`ifdef UART_FRAME_STAT_EN
            eg = exp_good; ee = exp_errc;
`else
            eg = 0; ee = 0;
`endif
            n_cmp++;
            if (bif.reg_wr !== exp_wr || bif.rd_req !== exp_rd || bif.frame_err !== exp_ferr ||
                bif.reg_addr !== 8'(exp_addr) || bif.reg_wdata !== 8'(exp_wdata) ||
                bif.err_code !== 2'(exp_code) || bif.busy !== m_in_frame ||
                bif.good_cnt !== 16'(eg) || bif.err_cnt !== 16'(ee)) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got wr=%b rd=%b ferr=%b addr=%h wdata=%h code=%0d busy=%b good=%0d errc=%0d expected wr=%b rd=%b ferr=%b addr=%h wdata=%h code=%0d busy=%b good=%0d errc=%0d",
                         $time, bif.reg_wr, bif.rd_req, bif.frame_err, bif.reg_addr, bif.reg_wdata,
                         bif.err_code, bif.busy, bif.good_cnt, bif.err_cnt,
                         exp_wr, exp_rd, exp_ferr, exp_addr[7:0], exp_wdata[7:0], exp_code, m_in_frame, eg, ee);
            end
            if (bif.reg_wr)    n_wr++;
            if (bif.rd_req)    n_rd++;
            if (bif.frame_err) n_ferr++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Called at posedge+2; byte is stb'd on the next edge, spacing = hold+gap.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        bif.uart_data = b;
        bif.uart_done = 1'b1;
        repeat (hold) @(posedge clk);
        #2;
        bif.uart_done = 1'b0;
        bif.uart_data = 8'($urandom);
        repeat (gap) @(posedge clk);
        #2;
    endtask

    task automatic rsend(input logic [7:0] b);
        send_byte(b, $urandom_range(2, 60), $urandom_range(1, 40));
    endtask

    task automatic rframe(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] s);
        rsend(8'hA5); rsend(c); rsend(a); rsend(d); rsend(s);
    endtask

    // Watchdog: the run is fixed-length, so expiry means something stalled.
    initial begin
        #(2_000_000);
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, e0;
        rst = 1'b1;
        bif.uart_done = 1'b0;
        bif.uart_data = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        chk("reset_busy", int'(bif.busy), 0);
        chk("reset_reg_wr", int'(bif.reg_wr), 0);
        chk("reset_err_code", int'(bif.err_code), 0);
        chk("reset_good_cnt", int'(bif.good_cnt), 0);

        // Write frame
        w0 = n_wr; e0 = n_ferr;
        rframe(8'h01, 8'h10, 8'h3C, 8'h4D);
        chk("wr_pulses", n_wr - w0, 1);
        chk("wr_addr", int'(bif.reg_addr), 8'h10);
        chk("wr_wdata", int'(bif.reg_wdata), 8'h3C);
        chk("wr_no_err", n_ferr - e0, 0);

        // Read frame
        w0 = n_wr; r0 = n_rd;
        rframe(8'h02, 8'h20, 8'h00, 8'h22);
        chk("rd_pulses", n_rd - r0, 1);
        chk("rd_addr", int'(bif.reg_addr), 8'h20);
        chk("rd_no_wr", n_wr - w0, 0);
        chk("rd_wdata_kept", int'(bif.reg_wdata), 8'h3C);

        // Bad checksum, then bad command
        w0 = n_wr; e0 = n_ferr;
        rframe(8'h01, 8'h10, 8'h3C, 8'h4E);
        chk("csum_err_pulse", n_ferr - e0, 1);
        chk("csum_err_code", int'(bif.err_code), 2);
        chk("csum_no_wr", n_wr - w0, 0);
        rframe(8'h03, 8'h00, 8'h00, 8'h03);
        chk("cmd_err_code", int'(bif.err_code), 3);

        // Junk then a valid write
        w0 = n_wr; e0 = n_ferr;
        rsend(8'h00); rsend(8'hFF); rsend(8'h5A);
        rframe(8'h01, 8'h10, 8'h3C, 8'h4D);
        chk("junk_one_wr", n_wr - w0, 1);
        chk("junk_no_err", n_ferr - e0, 0);
`ifdef UART_FRAME_STAT_EN
        chk("stat_good", int'(bif.good_cnt), 3);
        chk("stat_err", int'(bif.err_cnt), 2);
`else
        chk("stat_good_off", int'(bif.good_cnt), 0);
        chk("stat_err_off", int'(bif.err_cnt), 0);
`endif

        // Truncated frame times out
        e0 = n_ferr;
        send_byte(8'hA5, 5, 3);
        send_byte(8'h01, 5, TO_MAX + 10);
        chk("to_err_pulse", n_ferr - e0, 1);
        chk("to_err_code", int'(bif.err_code), 1);
        chk("to_busy_low", int'(bif.busy), 0);
        w0 = n_wr;
        rframe(8'h01, 8'h44, 8'h55, 8'h9A);
        chk("to_next_wr", n_wr - w0, 1);
        chk("to_next_addr", int'(bif.reg_addr), 8'h44);

        // Gap exactly at the limit: byte still accepted
        w0 = n_wr; e0 = n_ferr;
        send_byte(8'hA5, 5, 3);
        send_byte(8'h01, 5, TO_MAX + 1 - 5);
        rsend(8'h33); rsend(8'h11); rsend(8'h45);
        chk("edge_wr", n_wr - w0, 1);
        chk("edge_no_err", n_ferr - e0, 0);
        // One cycle past the limit: timeout
        send_byte(8'hA5, 5, 3);
        send_byte(8'h01, 5, TO_MAX + 2 - 5);
        send_byte(8'h01, 5, 5);
        chk("past_edge_err", n_ferr - e0, 1);
        chk("past_edge_code", int'(bif.err_code), 1);

        // Reset mid-frame
        w0 = n_wr; r0 = n_rd; e0 = n_ferr;
        rsend(8'hA5); rsend(8'h01); rsend(8'h10);
        rst = 1'b1;
        #1;
        chk("rst_busy", int'(bif.busy), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        chk("rst_no_strobes", (n_wr - w0) + (n_rd - r0) + (n_ferr - e0), 0);
        rframe(8'h01, 8'h77, 8'h01, 8'h79);
        chk("rst_next_wr", n_wr - w0, 1);
        chk("rst_next_wdata", int'(bif.reg_wdata), 8'h01);

        // Random traffic against the model
        for (int i = 0; i < 70; i++) begin
            int k;
            logic [7:0] c, a, d, s;
            k = $urandom_range(0, 7);
            a = 8'($urandom); d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) a = 8'hA5;
            case (k)
                0, 1: begin c = 8'h01; s = c + a + d; end
                2:    begin c = 8'h02; s = c + a + d; end
                3:    begin c = 8'($urandom_range(1, 2)); s = c + a + d + 8'($urandom_range(1, 255)); end
                4:    begin c = 8'($urandom_range(3, 255)); s = c + a + d; end
                default: begin c = 8'($urandom); s = 8'($urandom); end
            endcase
            if (k == 5) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) rsend(8'($urandom_range(0, 8'hA4)));
            end else if (k == 6) begin
                int n;
                n = $urandom_range(0, 3);
                rsend(8'hA5);
                for (int j = 0; j < n; j++) rsend(8'($urandom));
                repeat (TO_MAX + 2 + $urandom_range(0, 50)) @(posedge clk);
                #2;
            end else begin
                rframe(c, a, d, s);
            end
        end
        repeat (5) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
